// File: rtl/line_buffer_fetch_pkg.sv
// Shared raster geometry, data types and FSM encoding for the scanline fetch client.
package lb_pkg;
    localparam int H_ACTIVE       = 640;
    localparam int V_ACTIVE       = 480;
    localparam int H_TOTAL        = 800;
    localparam int V_TOTAL        = 525;
    localparam int WORDS_PER_LINE = 80;
    localparam int PIX_PER_WORD   = 8;
    localparam int RAM_DEPTH      = 2 * WORDS_PER_LINE;

    typedef logic [15:0]  pixel_t;
    typedef logic [127:0] sdram_word_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        NEXT
    } lb_state_t;
endpackage

// File: rtl/line_buffer_fetch_if.sv
// Read channel between the line buffer (master) and the SDRAM arbiter (slave).
interface line_buffer_fetch_if;
    import lb_pkg::*;

    logic        lb_sdram_Wait;
    logic        lb_sdram_ac;
    sdram_word_t lb_sdram_data;
    logic        lb_sdram_rd;
    logic [21:0] lb_sdram_addr;

    modport master (
        input  lb_sdram_Wait,
        input  lb_sdram_ac,
        input  lb_sdram_data,
        output lb_sdram_rd,
        output lb_sdram_addr
    );

    modport slave (
        output lb_sdram_Wait,
        output lb_sdram_ac,
        output lb_sdram_data,
        input  lb_sdram_rd,
        input  lb_sdram_addr
    );
endinterface

// File: rtl/line_buffer_fetch_ram.sv
// Ping-pong line store: two banks of one scanline each, one write port and one registered read port.
module line_buffer_ram
    import lb_pkg::*;
(
    input  logic        clk,
    input  logic        i_we,
    input  logic        i_wbank,
    input  logic [6:0]  i_wword,
    input  sdram_word_t i_wdata,
    input  logic        i_rbank,
    input  logic [6:0]  i_rword,
    output sdram_word_t o_rdata
);
    sdram_word_t r_mem [RAM_DEPTH];
    logic [7:0]  w_waddr;
    logic [7:0]  w_raddr;

    // Banks are packed back to back so the array stays at 160 entries.
    assign w_waddr = i_wbank ? 8'(WORDS_PER_LINE) + {1'b0, i_wword} : {1'b0, i_wword};
    assign w_raddr = i_rbank ? 8'(WORDS_PER_LINE) + {1'b0, i_rword} : {1'b0, i_rword};

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[w_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[w_raddr];
    end
endmodule

// File: rtl/line_buffer_fetch.sv
// Fetches the next visible scanline from SDRAM at end of line and streams the current one to VGA.
// IDLE: wait for trigger | REQ: request word, wait for ack | NEXT: advance word or finish line
module line_buffer_fetch
    import lb_pkg::*;
#(
    parameter logic [21:0] FB_BASE = 22'h000000
)
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic [9:0]                 DrawX,
    input  logic [9:0]                 DrawY,
    line_buffer_fetch_if.master        sdram,
    output logic                       lb_Busy,
    output pixel_t                     pixel_data,
    output logic                       pixel_valid,
    output logic                       lb_overrun
);
    localparam int unsigned MAX_WORD_ADDR =
        32'(FB_BASE) + 32'((V_ACTIVE - 1) * WORDS_PER_LINE + WORDS_PER_LINE - 1);

    if (MAX_WORD_ADDR > 32'h003F_FFFF) begin : g_addr_range_check
        $error("line_buffer_fetch: framebuffer end exceeds the 22-bit SDRAM word address space");
    end

    lb_state_t   r_state;
    lb_state_t   w_state_nxt;
    logic [9:0]  r_nl;
    logic [6:0]  r_word;
    logic [21:0] r_addr;
    logic        r_busy;
    logic        r_overrun;
    logic        r_pix_valid;
    logic [2:0]  r_pix_k;

    logic [9:0]  w_nl;
    logic        w_trig;
    logic [21:0] w_line_base;
    logic        w_rd;
    logic        w_we;
    logic        w_start;
    logic        w_adv;
    logic        w_in_active;
    logic [6:0]  w_rword;
    sdram_word_t w_rdata;

    assign w_nl        = (DrawY == 10'(V_TOTAL - 1)) ? 10'd0 : DrawY + 10'd1;
    assign w_trig      = (DrawX == 10'(H_TOTAL - 1)) && (w_nl < 10'(V_ACTIVE));
    // nl*80 as two shifts, widened first so no bits are lost.
    assign w_line_base = FB_BASE + ({12'd0, w_nl} << 6) + ({12'd0, w_nl} << 4);

    always_comb begin
        w_state_nxt = r_state;
        w_rd        = 1'b0;
        w_we        = 1'b0;
        w_start     = 1'b0;
        w_adv       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_trig) begin
                    w_start     = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                w_rd = ~sdram.lb_sdram_Wait;
                if (sdram.lb_sdram_ac) begin
                    w_we        = 1'b1;
                    w_state_nxt = NEXT;
                end
            end
            NEXT: begin
                if (r_word == 7'(WORDS_PER_LINE - 1)) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_adv       = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_nl      <= '0;
            r_word    <= '0;
            r_addr    <= '0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != IDLE);
            if (w_trig && r_busy) begin
                r_overrun <= 1'b1;
            end
            if (w_start) begin
                r_nl   <= w_nl;
                r_word <= '0;
                r_addr <= w_line_base;
            end else if (w_adv) begin
                r_word <= r_word + 7'd1;
                r_addr <= r_addr + 22'd1;
            end
        end
    end

    assign sdram.lb_sdram_rd   = w_rd;
    assign sdram.lb_sdram_addr = r_addr;
    assign lb_Busy             = r_busy;
    assign lb_overrun          = r_overrun;

    // Past column 639 DrawX[9:3] leaves the line; the output is masked anyway, so park the read address.
    assign w_in_active = (DrawX < 10'(H_ACTIVE)) && (DrawY < 10'(V_ACTIVE));
    assign w_rword     = w_in_active ? DrawX[9:3] : 7'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pix_valid <= 1'b0;
            r_pix_k     <= '0;
        end else begin
            r_pix_valid <= w_in_active;
            r_pix_k     <= DrawX[2:0];
        end
    end

    line_buffer_ram u_ram (
        .clk     (clk),
        .i_we    (w_we & ~reset),
        .i_wbank (r_nl[0]),
        .i_wword (r_word),
        .i_wdata (sdram.lb_sdram_data),
        .i_rbank (DrawY[0]),
        .i_rword (w_rword),
        .o_rdata (w_rdata)
    );

    assign pixel_valid = r_pix_valid;
    assign pixel_data  = r_pix_valid ? w_rdata[{r_pix_k, 4'b0000} +: 16] : '0;
endmodule

// File: tb/tb_line_buffer_fetch.sv
// Randomized bench for line_buffer_fetch with an SDRAM responder and a scanline-level reference model.
module tb_line_buffer_fetch;
    import lb_pkg::*;

    localparam logic [21:0] FB_BASE = 22'h010000;
    localparam logic [9:0]  IDLE_X  = 10'd700;
    localparam logic [9:0]  IDLE_Y  = 10'd500;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       lb_Busy;
    pixel_t     pixel_data;
    logic       pixel_valid;
    logic       lb_overrun;

    line_buffer_fetch_if sdram ();

    line_buffer_fetch #(.FB_BASE(FB_BASE)) dut (
        .clk         (clk),
        .reset       (reset),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .sdram       (sdram.master),
        .lb_Busy     (lb_Busy),
        .pixel_data  (pixel_data),
        .pixel_valid (pixel_valid),
        .lb_overrun  (lb_overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [127:0] m_mem   [2][WORDS_PER_LINE];
    bit           m_known [2][WORDS_PER_LINE];
    bit           m_busy = 0;
    bit           m_last = 0;
    bit           m_overrun = 0;
    int           m_line = 0;
    int           m_word = 0;
    bit           exp_valid = 0;
    bit           exp_known = 0;
    logic [15:0]  exp_pix = '0;
    bit           rst_seen = 0;
    bit           prev_ack = 0;

    // SDRAM responder state
    int lat = 2;
    bit pend = 0;
    int pend_cnt = 0;
    bit wait_rand = 0;
    bit pattern = 0;
    int stall_word = -1;
    int stall_cnt = 0;

    int acks = 0;
    int rd_cycles = 0;
    int first_addr = -1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] make_data();
        logic [127:0] d;
        if (pattern) begin
            for (int k = 0; k < PIX_PER_WORD; k++) d[16*k +: 16] = 16'(m_word * 8 + k);
        end else begin
            d = {$urandom, $urandom, $urandom, $urandom};
        end
        return d;
    endfunction

    task automatic step(input logic [9:0] x, input logic [9:0] y, input logic rst);
        logic         ac_now;
        logic [127:0] d;
        int           xi;
        int           yi;
        int           nl;
        bit           busy_next;
        @(posedge clk);
        #1;
        check("busy", lb_Busy, m_busy);
        check("overrun", lb_overrun, m_overrun);
        check("pix_valid", pixel_valid, exp_valid);
        if (exp_known) check("pix_data", pixel_data, exp_pix);

        DrawX = x;
        DrawY = y;
        reset = rst;
        ac_now = 1'b0;
        d = {$urandom, $urandom, $urandom, $urandom};
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                ac_now = 1'b1;
                pend = 0;
                d = make_data();
            end
        end
        sdram.lb_sdram_ac   = ac_now;
        sdram.lb_sdram_data = d;
        if (stall_cnt > 0) begin
            sdram.lb_sdram_Wait = 1'b1;
            stall_cnt--;
        end else begin
            sdram.lb_sdram_Wait = wait_rand ? ($urandom_range(3) == 0) : 1'b0;
        end
        #1;

        if (rst_seen) begin
            check("rst_rd", sdram.lb_sdram_rd, 0);
            check("rst_addr", sdram.lb_sdram_addr, 0);
        end
        check("rd_while_wait", sdram.lb_sdram_rd & sdram.lb_sdram_Wait, 0);
        check("rd_while_idle", sdram.lb_sdram_rd & ~m_busy, 0);
        check("rd_after_ack", sdram.lb_sdram_rd & prev_ack, 0);
        if (sdram.lb_sdram_rd) begin
            rd_cycles++;
            if (m_busy) begin
                check("rd_addr", sdram.lb_sdram_addr, 64'(FB_BASE) + 64'(m_line * WORDS_PER_LINE + m_word));
                if (m_word == 0 && first_addr < 0) first_addr = int'(sdram.lb_sdram_addr);
            end
            if (!pend && !ac_now && !rst) begin
                pend = 1;
                pend_cnt = lat;
            end
        end

        xi = int'(x);
        yi = int'(y);
        if (!rst && xi < H_ACTIVE && yi < V_ACTIVE) begin
            exp_valid = 1;
            exp_known = m_known[yi % 2][xi / 8];
            exp_pix   = m_mem[yi % 2][xi / 8][16 * (xi % 8) +: 16];
        end else begin
            exp_valid = 0;
            exp_known = 1;
            exp_pix   = '0;
        end

        prev_ack = ac_now && !rst;
        if (rst) begin
            m_busy = 0;
            m_last = 0;
            m_overrun = 0;
            pend = 0;
            stall_cnt = 0;
            rst_seen = 1;
        end else begin
            rst_seen = 0;
            nl = (yi == V_TOTAL - 1) ? 0 : yi + 1;
            busy_next = m_busy;
            if (m_last) busy_next = 0;
            m_last = 0;
            if (ac_now && m_busy) begin
                m_mem[m_line % 2][m_word] = d;
                m_known[m_line % 2][m_word] = 1;
                acks++;
                m_word++;
                if (m_word == stall_word) stall_cnt = 20;
                if (m_word == WORDS_PER_LINE) m_last = 1;
            end
            if (xi == H_TOTAL - 1 && nl < V_ACTIVE) begin
                if (m_busy) begin
                    m_overrun = 1;
                end else begin
                    busy_next = 1;
                    m_line = nl;
                    m_word = 0;
                    first_addr = -1;
                end
            end
            m_busy = busy_next;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(IDLE_X, IDLE_Y, 1'b0);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while ((m_busy || lb_Busy) && n < 5000) begin
            step(IDLE_X, IDLE_Y, 1'b0);
            n++;
        end
        check({tag, "_done"}, lb_Busy, 0);
    endtask

    task automatic fetch(input logic [9:0] y, input string tag);
        acks = 0;
        step(10'd799, y, 1'b0);
        wait_done(tag);
        check({tag, "_acks"}, acks, 80);
    endtask

    task automatic show_line(input int y);
        for (int x = 0; x < H_TOTAL; x++) step(10'(x), 10'(y), 1'b0);
        step(IDLE_X, IDLE_Y, 1'b0);
    endtask

    initial begin
        int y;
        int rd_before;
        int n;
        reset = 1'b1;
        DrawX = IDLE_X;
        DrawY = IDLE_Y;
        sdram.lb_sdram_Wait = 1'b0;
        sdram.lb_sdram_ac   = 1'b0;
        sdram.lb_sdram_data = '0;
        for (int b = 0; b < 2; b++)
            for (int w = 0; w < WORDS_PER_LINE; w++) m_known[b][w] = 0;

        step(IDLE_X, IDLE_Y, 1'b1);
        step(IDLE_X, IDLE_Y, 1'b1);
        idle(3);

        // plain grant, line 11 from DrawY 10
        lat = 2;
        fetch(10'd10, "grant");
        check("grant_first_addr", first_addr, 64'(FB_BASE) + 64'd880);

        // stall on word 5 while loading a pixel-index pattern
        pattern = 1;
        stall_word = 5;
        fetch(10'd10, "stall");
        stall_word = -1;
        check("stall_first_addr", first_addr, 64'(FB_BASE) + 64'd880);

        // display line 11: pixel equals its column
        for (int x = 0; x < H_TOTAL; x++) begin
            step(10'(x), 10'd11, 1'b0);
            if (x > 0) begin
                check("disp_px", pixel_data, (x - 1 < H_ACTIVE) ? 64'(x - 1) : 64'd0);
                check("disp_valid", pixel_valid, (x - 1 < H_ACTIVE) ? 64'd1 : 64'd0);
            end
        end
        wait_done("disp_next");
        pattern = 0;

        // random lines, latencies and arbiter stalls
        repeat (2) begin
            y = $urandom_range(0, 478);
            lat = $urandom_range(1, 6);
            wait_rand = 1;
            fetch(10'(y), "rand");
            check("rand_first_addr", first_addr, 64'(FB_BASE) + 64'((y + 1) * WORDS_PER_LINE));
            wait_rand = 0;
            show_line(y + 1);
            wait_done("rand_tail");
        end

        // frame wrap fetches line 0 into bank 0
        lat = 2;
        fetch(10'd524, "wrap");
        check("wrap_first_addr", first_addr, 64'(FB_BASE));
        for (int x = 0; x < H_ACTIVE; x++) step(10'(x), 10'd0, 1'b0);
        idle(2);
        rd_before = rd_cycles;
        for (int yy = V_ACTIVE - 1; yy < V_TOTAL - 1; yy++) begin
            step(10'd799, 10'(yy), 1'b0);
            idle(3);
        end
        check("blank_no_rd", rd_cycles - rd_before, 0);
        check("blank_busy", lb_Busy, 0);

        // overrun: second trigger lands mid-fetch
        lat = 12;
        acks = 0;
        step(10'd799, 10'd20, 1'b0);
        idle(799);
        step(10'd799, 10'd21, 1'b0);
        idle(1);
        check("overrun_set", lb_overrun, 1);
        wait_done("overrun");
        check("overrun_acks", acks, 80);
        idle(5);
        check("overrun_sticky", lb_overrun, 1);

        // reset mid-fetch
        lat = 2;
        acks = 0;
        step(10'd799, 10'd30, 1'b0);
        n = 0;
        while (m_word < 40 && n < 2000) begin
            step(IDLE_X, IDLE_Y, 1'b0);
            n++;
        end
        check("reached_word40", m_word, 40);
        step(IDLE_X, IDLE_Y, 1'b1);
        step(IDLE_X, IDLE_Y, 1'b0);
        check("rst_busy", lb_Busy, 0);
        check("rst_overrun", lb_overrun, 0);
        rd_before = rd_cycles;
        idle(10);
        check("rst_quiet", rd_cycles - rd_before, 0);
        fetch(10'd30, "restart");
        check("restart_first_addr", first_addr, 64'(FB_BASE) + 64'(31 * WORDS_PER_LINE));
        show_line(31);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
